// File: rtl/decoder_pkg.sv
// Shared types and constants for the registered 3-to-8 pulse decoder.
//   state_e     : FSM states of decoder38_pulse
//   CODE_W      : width of the binary select code
//   SEL_W       : number of one-hot select lines
//   PULSE_W_MIN : smallest legal pulse width in cycles
//   PULSE_W_MAX : largest legal pulse width in cycles
package decoder_pkg;

    typedef enum logic [1:0] {
        Idle,
        Pulse,
        Gap
    } state_e;

    localparam int unsigned CODE_W      = 3;
    localparam int unsigned SEL_W       = 8;
    localparam int unsigned PULSE_W_MIN = 1;
    localparam int unsigned PULSE_W_MAX = 255;

endpackage

// File: rtl/decoder38.sv
// Pure combinational 3-to-8 one-hot decoder.
//   code_i : binary code, 0..7
//   sel_o  : one-hot select, sel_o[code_i] = 1, all other bits 0
module decoder38
    import decoder_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [SEL_W-1:0]  sel_o
);

    always_comb begin
        sel_o         = '0;
        sel_o[code_i] = 1'b1;
    end

endmodule

// File: rtl/decoder38_pulse.sv
// Registered 3-to-8 decoder with valid/ready handshake and timed one-hot pulses.
// Single mode emits one PULSE_W-cycle pulse per accepted code; scan mode sweeps
// codes 0..7. Every pulse is followed by an all-zero GAP cycle (break-before-make).
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   en    : global enable, low freezes all state
//   scan  : auto-scan request
//   x,y,z : code bits 2,1,0
//   valid : code presented
//   ready : code accepted this cycle (valid & ready = handshake)
//   D     : registered one-hot select
//   busy  : FSM not idle
//   done  : registered one-cycle end-of-transaction / end-of-sweep pulse
module decoder38_pulse
    import decoder_pkg::*;
#(
    parameter int unsigned PULSE_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             scan,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    input  logic             valid,
    output logic             ready,
    output logic [SEL_W-1:0] D,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = $clog2(PULSE_W + 1);
    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(PULSE_W - 1);

    if (PULSE_W < PULSE_W_MIN || PULSE_W > PULSE_W_MAX) begin : gen_bad_pulse_w
        $error("decoder38_pulse: PULSE_W out of range 1..255");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [SEL_W-1:0]   d_q, d_d;
    logic               done_q, done_d;
    logic               scan_txn_q, scan_txn_d;

    logic [CODE_W-1:0]  load_code;
    logic [SEL_W-1:0]   load_sel;

    // Code that would start the next pulse: next slot from GAP, otherwise
    // slot 0 for a scan start or the sampled inputs for a handshake.
    always_comb begin
        if (state_q == Gap) begin
            load_code = code_q + CODE_W'(1);
        end else if (scan) begin
            load_code = '0;
        end else begin
            load_code = {x, y, z};
        end
    end

    decoder38 u_decoder38 (
        .code_i (load_code),
        .sel_o  (load_sel)
    );

    assign ready = (state_q == Idle) & en & ~scan;
    assign busy  = (state_q != Idle);
    assign D     = d_q;
    assign done  = done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        d_d        = d_q;
        scan_txn_d = scan_txn_q;
        done_d     = 1'b0;

        if (en) begin
            unique case (state_q)
                Idle: begin
                    // Scan start wins; ready is already low when scan is high.
                    if (scan || valid) begin
                        state_d    = Pulse;
                        code_d     = load_code;
                        cnt_d      = CntLoad;
                        d_d        = load_sel;
                        scan_txn_d = scan;
                    end
                end
                Pulse: begin
                    if (cnt_q == '0) begin
                        state_d = Gap;
                        d_d     = '0;
                        // done lands in the GAP cycle that ends the transaction/sweep.
                        done_d  = ~scan_txn_q | (code_q == CODE_W'(7));
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                Gap: begin
                    if (scan_txn_q && scan) begin
                        state_d = Pulse;
                        code_d  = load_code;
                        cnt_d   = CntLoad;
                        d_d     = load_sel;
                    end else begin
                        state_d = Idle;
                    end
                end
                default: state_d = Idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= Idle;
            cnt_q      <= '0;
            code_q     <= '0;
            d_q        <= '0;
            done_q     <= 1'b0;
            scan_txn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            d_q        <= d_d;
            done_q     <= done_d;
            scan_txn_q <= scan_txn_d;
        end
    end

endmodule
